// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch states, jump-select codes, decoder opcodes
// and a sign-extension helper.
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    FS_RUN     = 2'd0,
    FS_WAIT_IN = 2'd1,
    FS_HALT    = 2'd2
  } fetch_state_e;

  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_ABS = 2'b01;
  localparam logic [1:0] JMP_REG = 2'b10;

  localparam int unsigned OPCODE_WIDTH = 6;
  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_WIDTH-1:0] OP_INPUT = 6'h3E;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = 6'h3F;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection: absolute jump, register jump, taken
// branch or sequential, all modulo 2^PC_WIDTH.
module next_pc_mux
  import cpu_defs_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 10
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [1:0]          jump,
  input  logic                branch,
  input  logic                alu_zero,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic [PC_WIDTH-1:0] reg_target,
  input  logic [15:0]         branch_offset,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic [PC_WIDTH-1:0] pc_plus_one
);

  logic [PC_WIDTH-1:0] offset_ext;

  assign pc_plus_one = pc + PC_WIDTH'(1);
  assign offset_ext  = PC_WIDTH'(sext16(branch_offset));

  // Jump codes take priority over branch; code 11 falls through as sequential.
  always_comb begin
    next_pc = pc_plus_one;
    if (jump == JMP_ABS) begin
      next_pc = jump_target;
    end else if (jump == JMP_REG) begin
      next_pc = reg_target;
    end else if (branch && alu_zero) begin
      next_pc = pc_plus_one + offset_ext;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and run-state machine (RUN / WAIT_IN / HALT).
// Optional FETCH_RETIRE_COUNT_EN adds a committed-instruction counter.
module fetch_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instruction,
  input  logic [1:0]             jump,
  input  logic                   branch,
  input  logic                   alu_zero,
  input  logic [25:0]            jump_target,
  input  logic [31:0]            reg_target,
  input  logic [15:0]            branch_offset,
  input  logic                   halt,
  input  logic                   input_flag,
  input  logic                   input_confirm,
  output logic                   stall,
  output logic                   halted,
`ifdef FETCH_RETIRE_COUNT_EN
  output logic [31:0]            retired_count,
`endif
  output logic [PC_WIDTH-1:0]    pc_plus_one
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                confirm_q, confirm_d;
  logic                confirm_edge;
  logic                advance;
  logic [PC_WIDTH-1:0] next_pc;

  assign confirm_edge = input_confirm & ~confirm_q;
  assign confirm_d    = input_confirm;
  assign pc           = pc_q;
  assign instruction  = imem_data;

  next_pc_mux #(.PC_WIDTH(PC_WIDTH)) u_next_pc_mux (
    .pc            (pc_q),
    .jump          (jump),
    .branch        (branch),
    .alu_zero      (alu_zero),
    .jump_target   (PC_WIDTH'(jump_target)),
    .reg_target    (PC_WIDTH'(reg_target)),
    .branch_offset (branch_offset),
    .next_pc       (next_pc),
    .pc_plus_one   (pc_plus_one)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stall   = 1'b0;
    halted  = 1'b0;
    advance = 1'b0;
    case (state_q)
      FS_RUN: begin
        if (halt) begin
          stall   = 1'b1;
          state_d = FS_HALT;
        end else if (input_flag && !confirm_edge) begin
          stall   = 1'b1;
          state_d = FS_WAIT_IN;
        end else begin
          advance = 1'b1;
        end
      end
      FS_WAIT_IN: begin
        // Only a fresh press commits; a level held from before entry does not.
        if (confirm_edge) begin
          advance = 1'b1;
          state_d = FS_RUN;
        end else begin
          stall = 1'b1;
        end
      end
      FS_HALT: begin
        halted = 1'b1;
        stall  = 1'b1;
      end
      default: state_d = FS_RUN;
    endcase
    if (advance) pc_d = next_pc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FS_RUN;
      pc_q      <= PC_WIDTH'(RESET_PC);
      confirm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      confirm_q <= confirm_d;
    end
  end

`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0] retired_count_q, retired_count_d;

  always_comb begin
    retired_count_d = retired_count_q;
    if (!stall && state_q != FS_HALT) retired_count_d = retired_count_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) retired_count_q <= 32'd0;
    else       retired_count_q <= retired_count_d;
  end

  assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (default width plus a
// 4-bit PC instance for wrap checks).
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_data;
  logic [1:0]  jump;
  logic        branch, alu_zero, halt, input_flag, input_confirm;
  logic [25:0] jump_target;
  logic [31:0] reg_target;
  logic [15:0] branch_offset;

  logic [9:0]  pc, pc_plus_one;
  logic [31:0] instruction;
  logic        stall, halted;
  logic [3:0]  pc4, pc_plus_one4;
  logic [31:0] instruction4;
  logic        stall4, halted4;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0] retired_count, retired_count4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_sequencer u_dut (
    .clock         (clock),
    .reset         (reset),
    .imem_data     (imem_data),
    .pc            (pc),
    .instruction   (instruction),
    .jump          (jump),
    .branch        (branch),
    .alu_zero      (alu_zero),
    .jump_target   (jump_target),
    .reg_target    (reg_target),
    .branch_offset (branch_offset),
    .halt          (halt),
    .input_flag    (input_flag),
    .input_confirm (input_confirm),
    .stall         (stall),
    .halted        (halted),
`ifdef FETCH_RETIRE_COUNT_EN
    .retired_count (retired_count),
`endif
    .pc_plus_one   (pc_plus_one)
  );

  fetch_sequencer #(.PC_WIDTH(4)) u_dut4 (
    .clock         (clock),
    .reset         (reset),
    .imem_data     (imem_data),
    .pc            (pc4),
    .instruction   (instruction4),
    .jump          (jump),
    .branch        (branch),
    .alu_zero      (alu_zero),
    .jump_target   (jump_target),
    .reg_target    (reg_target),
    .branch_offset (branch_offset),
    .halt          (halt),
    .input_flag    (input_flag),
    .input_confirm (input_confirm),
    .stall         (stall4),
    .halted        (halted4),
`ifdef FETCH_RETIRE_COUNT_EN
    .retired_count (retired_count4),
`endif
    .pc_plus_one   (pc_plus_one4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic plain();
    jump = 2'b00; branch = 1'b0; alu_zero = 1'b0; halt = 1'b0; input_flag = 1'b0;
    jump_target = 26'd0; reg_target = 32'd0; branch_offset = 16'd0;
  endtask

  initial begin
    reset = 1'b1; imem_data = 32'hFC00_0000; input_confirm = 1'b0;
    plain();
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("reset_pc", 32'(pc), 32'd0);
    check_eq("reset_stall", 32'(stall), 32'd0);
    check_eq("reset_halted", 32'(halted), 32'd0);
    check_eq("reset_pc_plus_one", 32'(pc_plus_one), 32'd1);
    check_eq("instr_pass", instruction, 32'hFC00_0000);

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_pc", 32'(pc), 32'(i));
      check_eq("seq_pc_plus_one", 32'(pc_plus_one), 32'(i + 1));
      check_eq("seq_stall", 32'(stall), 32'd0);
      tick();
    end
    check_eq("seq_pc4", 32'(pc), 32'd4);
`ifdef FETCH_RETIRE_COUNT_EN
    check_eq("retired_after_4", retired_count, 32'd4);
`endif
    tick();
    check_eq("pc_at_5", 32'(pc), 32'd5);

    // Taken branch with negative offset: 5+1-3 = 3
    branch = 1'b1; alu_zero = 1'b1; branch_offset = 16'hFFFD;
    tick();
    check_eq("branch_taken", 32'(pc), 32'd3);
    plain(); jump = 2'b01; jump_target = 26'd5;
    tick();
    check_eq("jump_back_5", 32'(pc), 32'd5);
    plain(); branch = 1'b1; alu_zero = 1'b0; branch_offset = 16'hFFFD;
    tick();
    check_eq("branch_not_taken", 32'(pc), 32'd6);
    plain();
    tick();
    check_eq("pc_at_7", 32'(pc), 32'd7);

    // Jump beats branch, then register jump, then code 11 is sequential
    jump = 2'b01; jump_target = 26'h40; branch = 1'b1; alu_zero = 1'b1; branch_offset = 16'h0010;
    tick();
    check_eq("jump_abs_over_branch", 32'(pc), 32'h40);
    plain(); jump = 2'b10; reg_target = 32'hFFFF_F123;
    tick();
    check_eq("jump_reg", 32'(pc), 32'h123);
    plain(); jump = 2'b11; jump_target = 26'h3;
    tick();
    check_eq("jump_11_seq", 32'(pc), 32'h124);

    // Reach pc 9 with confirm already held high
    plain(); jump = 2'b01; jump_target = 26'd9; input_confirm = 1'b1;
    tick();
    check_eq("pc_at_9", 32'(pc), 32'd9);
    plain(); input_flag = 1'b1;
    #1;
    check_eq("input_held_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("wait_in_pc", 32'(pc), 32'd9);
      check_eq("wait_in_stall", 32'(stall), 32'd1);
    end
    input_confirm = 1'b0;
    tick();
    check_eq("release_pc", 32'(pc), 32'd9);
    check_eq("release_stall", 32'(stall), 32'd1);
    input_confirm = 1'b1;
    #1;
    check_eq("press_commit_stall", 32'(stall), 32'd0);
    tick();
    check_eq("press_advance", 32'(pc), 32'd10);
    input_flag = 1'b0; input_confirm = 1'b0;
    #1;
    check_eq("run_after_input_stall", 32'(stall), 32'd0);
    tick();
    check_eq("pc_at_11", 32'(pc), 32'd11);

    // Input with fresh edge while in RUN commits immediately
    input_flag = 1'b1; input_confirm = 1'b1;
    #1;
    check_eq("run_edge_stall", 32'(stall), 32'd0);
    tick();
    check_eq("run_edge_pc", 32'(pc), 32'd12);

    // Halt at 12
    plain(); input_confirm = 1'b0; halt = 1'b1;
    #1;
    check_eq("halt_cycle_stall", 32'(stall), 32'd1);
    check_eq("halt_cycle_halted", 32'(halted), 32'd0);
    tick();
    plain(); jump = 2'b01; jump_target = 26'h55; input_flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      input_confirm = i[0];
      #1;
      check_eq("halt_pc", 32'(pc), 32'd12);
      check_eq("halt_halted", 32'(halted), 32'd1);
      check_eq("halt_stall", 32'(stall), 32'd1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; plain(); input_confirm = 1'b0;
    #1;
    check_eq("halt_reset_pc", 32'(pc), 32'd0);
    check_eq("halt_reset_halted", 32'(halted), 32'd0);
    check_eq("halt_reset_stall", 32'(stall), 32'd0);

    // Reset during WAIT_IN
    input_flag = 1'b1;
    tick();
    check_eq("wait_entry_pc", 32'(pc), 32'd0);
    check_eq("wait_entry_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; input_flag = 1'b0;
    #1;
    check_eq("wait_reset_stall", 32'(stall), 32'd0);
    check_eq("wait_reset_pc", 32'(pc), 32'd0);
    tick();
    check_eq("wait_reset_run", 32'(pc), 32'd1);

    // Negative branch below zero wraps: 1+1-3 = -1 -> 1023, then 1023+1 -> 0
    branch = 1'b1; alu_zero = 1'b1; branch_offset = 16'hFFFD;
    tick();
    check_eq("branch_wrap", 32'(pc), 32'd1023);
    check_eq("ppo_wrap", 32'(pc_plus_one), 32'd0);
    plain();
    tick();
    check_eq("seq_wrap", 32'(pc), 32'd0);

    // 4-bit PC instance: 15 -> 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check_eq("pc4_at_15", 32'(pc4), 32'd15);
    check_eq("pc4_ppo_wrap", 32'(pc_plus_one4), 32'd0);
    tick();
    check_eq("pc4_wrap", 32'(pc4), 32'd0);
`ifdef FETCH_RETIRE_COUNT_EN
    check_eq("retired4_count", retired_count4, 32'd16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Upstream neighbour of the opcode decoder: holds the program counter, presents the addressed instruction word to decode, and selects the next PC from the decoder's Jump/Branch controls. It also owns the processor run state: it stalls on an input instruction until the operator confirms, and it freezes permanently on halt. Single-cycle datapath with word-addressed instruction memory and combinational read.

Parameters:
PC_WIDTH, 10, instruction-memory address width (word address).
INSTR_WIDTH, 32, instruction word width.
RESET_PC, 0, PC value loaded on reset.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
imem_data  input  INSTR_WIDTH  instruction word read combinationally at pc.
pc  output  PC_WIDTH  current PC, drives instruction-memory address.
instruction  output  INSTR_WIDTH  equals imem_data; bits [31:26] feed the decoder opcode.
jump  input  2  from decoder: 00 sequential/branch, 01 absolute target, 10 register target, 11 treated as 00.
branch  input  1  from decoder, beq.
alu_zero  input  1  ALU zero flag.
jump_target  input  26  instruction[25:0].
reg_target  input  32  register-file read data for jr.
branch_offset  input  16  instruction[15:0], signed word offset.
halt  input  1  from decoder.
input_flag  input  1  from decoder, current instruction is Input.
input_confirm  input  1  operator confirm level, already synchronised to clock.
stall  output  1  high when the current instruction must not commit; gates regWrite/memWrite.
halted  output  1  processor frozen.
pc_plus_one  output  PC_WIDTH  pc+1, the jal link value.

Behaviour:
- Reset (synchronous, active-high) dominates everything: pc=RESET_PC, state=RUN, confirm_q=0, stall=0, halted=0. This holds in any state, including mid-WAIT_IN and HALT.
- Edge detect: confirm_q registers input_confirm every cycle. confirm_edge = input_confirm & ~confirm_q.
- States: RUN, WAIT_IN, HALT (encoded 2 bits).
- RUN:
  - halt=1: go to HALT next cycle and hold pc. The halt instruction does not commit (stall=1 that cycle).
  - else if input_flag=1 and confirm_edge=0: stall=1, pc held, go to WAIT_IN.
  - else if input_flag=1 and confirm_edge=1: commit this cycle (stall=0), advance pc, stay in RUN.
  - else: advance pc, stall=0.
- WAIT_IN:
  - stall=1 and pc held until confirm_edge=1.
  - On that cycle stall=0 (input value written), pc advances, and the state returns to RUN.
  - A level held high from before entry produces no edge; the operator must release and press again.
- HALT: halted=1, stall=1, pc frozen. Only reset exits; all control inputs are ignored.
- Next-PC priority on advance:
  - jump=01: pc = jump_target[PC_WIDTH-1:0].
  - jump=10: pc = reg_target[PC_WIDTH-1:0].
  - branch & alu_zero: pc = pc+1+sext(branch_offset).
  - otherwise: pc = pc+1.
- Arithmetic is modulo 2^PC_WIDTH; pc+1 wraps from all-ones to 0, and a negative offset below 0 wraps.
- If branch=1 and jump≠00 simultaneously, jump wins.
- confirm_edge outside WAIT_IN or an input instruction is ignored.
- stall and halted are combinational from state and inputs; pc is registered; latency to a new pc is 1 cycle.

Optional Feature:
Macro FETCH_RETIRE_COUNT_EN.
- Defined: adds output port retired_count (32 bits). It resets to 0 and increments, wrapping, on every cycle where stall=0 and state≠HALT, i.e. every committed instruction.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - the fetch state encoding (FS_RUN=0, FS_WAIT_IN=1, FS_HALT=2);
  - the jump-select constants (JMP_SEQ=00, JMP_ABS=01, JMP_REG=10);
  - the opcode constants used by the decoder.
- One sub-module, next_pc_mux: purely combinational next-PC selection and sign extension. The state machine and registers stay in fetch_sequencer.

Test Plan:
- Reset with 4 sequential plain instructions -> pc 0,1,2,3 on successive cycles; stall=0; pc_plus_one=pc+1.
- At pc=5, drive branch=1, alu_zero=1, offset=0xFFFD -> next pc=3; same with alu_zero=0 -> next pc=6.
- At pc=7, drive jump=01, jump_target=0x40, branch=1, alu_zero=1 -> next pc=0x40 (jump beats branch); jump=10 with reg_target=0x123 -> pc=0x123.
- At pc=9, input_flag=1 with input_confirm already held high -> stall=1 and pc=9 for 5 cycles; release then raise confirm -> one cycle stall=0, next pc=10.
- halt=1 at pc=12 -> halted=1, stall=1, pc=12 for 20 cycles regardless of jump/input; assert reset -> pc=0, halted=0 next cycle.
- Reset during WAIT_IN, and pc wrap at PC_WIDTH=4 from 15 -> state RUN with pc=0; 15+1 wraps to 0. With FETCH_RETIRE_COUNT_EN, the count equals the number of committed instructions (stalled cycles excluded).
